// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the N:1 arbitrating output-register mux.
//   ARB_FIXED / ARB_RR : arbitration mode selectors for ARB_MODE
//   state_e            : output register occupancy (EMPTY / FULL)
//   idx_w()            : channel-index width, never less than one bit
// -----------------------------------------------------------------------------
package mux_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // A single channel still needs a one-bit index port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational arbiter shared by both arbitration modes.
//   req       : request vector, one bit per channel
//   ptr       : round-robin start index (ignored when mode = 0)
//   mode      : 0 = fixed priority (index 0 highest), 1 = round-robin
//   grant     : one-hot grant, all zero when nothing requests
//   grant_idx : binary index of the granted channel (0 when none)
//   grant_vld : at least one request present, grant is meaningful
// -----------------------------------------------------------------------------
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              mode,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_vld
);

  // Fixed priority is just round-robin with the start pointer pinned at 0,
  // so one rotating scan covers both modes.
  always_comb begin
    int base;
    int idx;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    base      = mode ? int'(ptr) : 0;
    // Guards non-power-of-two channel counts where ptr has spare codes.
    if (base >= NUM_CH) base = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (base + k) % NUM_CH;
      if (!grant_vld && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
        grant_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux_nx1.sv
// -----------------------------------------------------------------------------
// arb_mux_nx1
// N-input arbitrating multiplexer feeding a single registered output slot
// with valid/ready handshakes on both sides.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_data    : packed channel words, channel i at [i*WIDTH +: WIDTH]
//   in_valid   : per-channel request
//   in_ready   : per-channel accept, at most one bit high
//   out_data   : registered word of the last accepted transfer
//   out_valid  : out_data holds an unconsumed word
//   out_ready  : downstream accept
//   out_ch     : channel index that supplied out_data
// -----------------------------------------------------------------------------
module arb_mux_nx1
  import mux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_CH   = 4,
  parameter int ARB_MODE = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH*WIDTH-1:0]   in_data,
  input  logic [NUM_CH-1:0]         in_valid,
  output logic [NUM_CH-1:0]         in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [idx_w(NUM_CH)-1:0]  out_ch
);

  localparam int IDX_W = idx_w(NUM_CH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [IDX_W-1:0]   out_ch_q, out_ch_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NUM_CH-1:0]  grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_vld;
  logic               can_load;
  logic               in_hs;
  logic [WIDTH-1:0]   sel_data;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr_q),
    .mode      (ARB_MODE == ARB_RR),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // The slot can take a new word when it is empty or is being drained this
  // cycle. rst_n gates the accept so no upstream handshake is signalled while
  // the register is held in reset.
  always_comb begin
    can_load = (state_q == ST_EMPTY) || out_ready;
    in_hs    = can_load && grant_vld && rst_n;
    in_ready = in_hs ? grant : '0;
  end

  // One-hot select; non-granted channel words never reach the register.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Next-state: a load takes precedence, which gives simultaneous drain and
  // refill (one word per cycle) when downstream is ready.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    rr_ptr_d   = rr_ptr_q;
    if (in_hs) begin
      state_d    = ST_FULL;
      out_data_d = sel_data;
      out_ch_d   = grant_idx;
      if (int'(grant_idx) == NUM_CH - 1) rr_ptr_d = '0;
      else                               rr_ptr_d = grant_idx + 1'b1;
    end else if ((state_q == ST_FULL) && out_ready) begin
      // Drained with nothing to replace it: data and index stay as they were.
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      out_ch_q   <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_arb_mux_nx1.sv
module tb_arb_mux_nx1;

  localparam int W  = 32;
  localparam int NC = 4;

  logic            clk;
  logic            rst_n;
  logic [W-1:0]    ch_data [NC];
  logic [NC*W-1:0] in_data;
  logic [NC-1:0]   in_valid;
  logic            out_ready;

  logic [NC-1:0]   rr_in_ready, fp_in_ready;
  logic [W-1:0]    rr_out_data, fp_out_data;
  logic            rr_out_valid, fp_out_valid;
  logic [1:0]      rr_out_ch, fp_out_ch;

  int total;
  int bad;

  assign in_data = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

  arb_mux_nx1 #(.WIDTH(W), .NUM_CH(NC), .ARB_MODE(1)) dut_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (rr_in_ready),
    .out_data  (rr_out_data),
    .out_valid (rr_out_valid),
    .out_ready (out_ready),
    .out_ch    (rr_out_ch)
  );

  arb_mux_nx1 #(.WIDTH(W), .NUM_CH(NC), .ARB_MODE(0)) dut_fp (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (fp_in_ready),
    .out_data  (fp_out_data),
    .out_valid (fp_out_valid),
    .out_ready (out_ready),
    .out_ch    (fp_out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; registered outputs are then stable.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b1;
    in_valid  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < NC; i++) ch_data[i] = 32'hA000_0000 + i;

    // Reset state, with requests present during reset
    #1 rst_n = 1'b0;
    in_valid = 4'hF;
    #2;
    chk("rst_out_valid", rr_out_valid, 0);
    chk("rst_out_data",  rr_out_data,  0);
    chk("rst_out_ch",    rr_out_ch,    0);
    chk("rst_in_ready",  rr_in_ready,  0);
    chk("rst_rr_ptr",    dut_rr.rr_ptr_q, 0);
    cyc();
    cyc();
    in_valid = '0;
    #1 rst_n = 1'b1;
    cyc();

    // Round-robin, all channels requesting, downstream always ready
    in_valid  = 4'hF;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_in_ready", rr_in_ready, 4'b0001 << (k % 4));
      cyc();
      chk("rr_out_valid", rr_out_valid, 1);
      chk("rr_out_ch",    rr_out_ch,    k % 4);
      chk("rr_out_data",  rr_out_data,  32'hA000_0000 + (k % 4));
    end
    in_valid = '0;

    // Fixed priority: channels 1 and 3 requesting
    do_reset();
    in_valid  = 4'b1010;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("fp_in_ready", fp_in_ready, 4'b0010);
      cyc();
      chk("fp_out_ch",   fp_out_ch,   1);
      chk("fp_out_data", fp_out_data, 32'hA000_0001);
    end
    in_valid = '0;

    // Backpressure: hold a ch2 word for five cycles
    do_reset();
    ch_data[2] = 32'h1234_5678;
    in_valid   = 4'b0100;
    out_ready  = 1'b1;
    cyc();
    chk("bp_load_ch",   rr_out_ch,   2);
    chk("bp_load_data", rr_out_data, 32'h1234_5678);
    chk("bp_rr_ptr",    dut_rr.rr_ptr_q, 3);
    out_ready = 1'b0;
    in_valid  = 4'hF;
    ch_data[2] = 32'h5555_AAAA;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_in_ready", rr_in_ready, 0);
      cyc();
      chk("bp_hold_valid", rr_out_valid, 1);
      chk("bp_hold_ch",    rr_out_ch,    2);
      chk("bp_hold_data",  rr_out_data,  32'h1234_5678);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", rr_in_ready, 4'b1000);
    cyc();
    chk("bp_next_ch",    rr_out_ch,    3);
    chk("bp_next_data",  rr_out_data,  32'hA000_0003);
    chk("bp_next_valid", rr_out_valid, 1);
    in_valid   = '0;
    ch_data[2] = 32'hA000_0002;

    // Wrap: rr_ptr=3, only ch0 and ch3 requesting
    do_reset();
    in_valid = 4'b0100;
    cyc();
    chk("wrap_ptr3", dut_rr.rr_ptr_q, 3);
    in_valid = 4'b1001;
    #1;
    chk("wrap_ready3", rr_in_ready, 4'b1000);
    cyc();
    chk("wrap_ch3",  rr_out_ch, 3);
    chk("wrap_ptr0", dut_rr.rr_ptr_q, 0);
    #1;
    chk("wrap_ready0", rr_in_ready, 4'b0001);
    cyc();
    chk("wrap_ch0",  rr_out_ch, 0);
    chk("wrap_ptr1", dut_rr.rr_ptr_q, 1);

    // Drain: last word consumed, no further requests
    in_valid = '0;
    cyc();
    chk("drain_valid", rr_out_valid, 0);
    chk("drain_state", dut_rr.state_q, 0);
    chk("drain_data",  rr_out_data, 32'hA000_0000);
    chk("drain_ch",    rr_out_ch, 0);
    chk("drain_ptr",   dut_rr.rr_ptr_q, 1);
    cyc();
    chk("idle_valid", rr_out_valid, 0);

    // Reset while FULL holding 0xDEADBEEF
    ch_data[1] = 32'hDEAD_BEEF;
    in_valid   = 4'b0010;
    cyc();
    chk("mid_load_data", rr_out_data, 32'hDEAD_BEEF);
    chk("mid_ptr2",      dut_rr.rr_ptr_q, 2);
    out_ready = 1'b0;
    in_valid  = '0;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rr_out_valid, 0);
    chk("mid_rst_data",  rr_out_data,  0);
    chk("mid_rst_ptr",   dut_rr.rr_ptr_q, 0);
    chk("mid_rst_ch",    rr_out_ch, 0);
    #1 rst_n = 1'b1;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    #1;
    chk("post_rst_ready", rr_in_ready, 4'b0001);
    cyc();
    chk("post_rst_ch", rr_out_ch, 0);
    in_valid = '0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arb_mux_nx1.md
ARB_MUX_NX1 -- requirements
Module: arb_mux_nx1

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits (>=1).
REQ-002 SHALL have parameter NUM_CH, default 4, number of input channels (>=1).
REQ-003 SHALL have parameter ARB_MODE, default 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_data  input  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid  input  NUM_CH  per-channel request.
REQ-008 SHALL have port in_ready  output  NUM_CH  per-channel accept, at most one bit high.
REQ-009 SHALL have port out_data  output  WIDTH  registered selected word.
REQ-010 SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-011 SHALL have port out_ready  input  1  downstream accepts when high with out_valid.
REQ-012 SHALL have port out_ch  output  max(1,clog2(NUM_CH))  channel index of the word in out_data.

Function
REQ-013 SHALL implement a two-state machine: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 SHALL define "can_load" = EMPTY, or FULL with out_ready=1.
REQ-015 SHALL, when can_load and any in_valid is high, assert in_ready for exactly the granted channel in the same cycle (combinational, may depend on out_ready).
REQ-016 SHALL, on an input handshake, register in_data of the granted channel into out_data and its index into out_ch at the next edge; state becomes FULL (one-cycle latency).
REQ-017 SHALL, in FULL with out_ready=1 and no in_valid, go to EMPTY; out_data/out_ch retain last value.
REQ-018 SHALL, in FULL with out_ready=0, hold out_data, out_ch, out_valid stable and keep all in_ready low.
REQ-019 SHALL sustain one transfer per cycle when out_ready stays high and requests are present (simultaneous output drain and input load).
REQ-020 SHALL, in ARB_MODE=0, grant the lowest-indexed valid channel.
REQ-021 SHALL, in ARB_MODE=1, grant the first valid channel at or after pointer rr_ptr, searching upward with wrap from NUM_CH-1 to 0.
REQ-022 SHALL update rr_ptr to (granted index + 1) mod NUM_CH only on an input handshake; no handshake leaves rr_ptr unchanged.
REQ-023 SHALL treat NUM_CH=1 as a one-entry registered pipeline stage; out_ch constant 0.
REQ-024 SHALL ignore in_data of non-granted channels and in_valid deassertion without handshake.

Reset
REQ-025 SHALL, while rst_n=0, force state EMPTY, out_valid=0, out_data=0, out_ch=0, rr_ptr=0, in_ready all 0, independent of clk.
REQ-026 SHALL discard any held word on reset mid-operation; first grant after release follows rr_ptr=0.

Structure
REQ-027 SHALL place ARB_FIXED=0 / ARB_RR=1 constants and the EMPTY/FULL state type in shared package mux_pkg.
REQ-028 SHALL use one combinational sub-module rr_arbiter (inputs: request vector, pointer, mode; output: one-hot grant and index).

Verification
REQ-029 SHALL test reset: rst_n low mid-FULL with out_data=0xDEADBEEF -> out_valid=0, out_data=0, rr_ptr=0 immediately.
REQ-030 SHALL test round-robin: ARB_MODE=1, all 4 valid, out_ready=1 continuously -> out_ch sequence 0,1,2,3,0 on consecutive cycles, one per cycle.
REQ-031 SHALL test fixed priority: ARB_MODE=0, channels 1 and 3 valid, out_ready=1 -> channel 1 granted every cycle, channel 3 never.
REQ-032 SHALL test backpressure: load ch2 data 0x12345678, out_ready=0 for 5 cycles -> out_data/out_ch stable, in_ready=0; out_ready=1 -> ch2 word consumed, next grant same cycle.
REQ-033 SHALL test wrap: rr_ptr=3, only ch0 and ch3 valid -> ch3 granted, then ch0, rr_ptr returns to 1.
REQ-034 SHALL test drain: single word accepted, then no requests, out_ready=1 -> out_valid drops after one cycle, state EMPTY.
